minterm_list_encoder: RTL and testbench
=======================================

# minterm_list_encoder

Serialising encoder for 8-input truth tables, the inverse of the decoder-based function builders. It accepts a full truth-table word, which is the same vector a 3-to-8 decoder plus OR/AND gate network realises. It then emits, one per cycle, the 3-bit index of every minterm (SOP mode) or every maxterm (POS mode), in ascending order. It sits between a truth-table source (register file or test stimulus) and any consumer that needs the Σm/ΠM term list.

## Interface
Parameters:
- WIDTH, 8, truth-table width; must be a power of two ≥ 2
- IDX_W, $clog2(WIDTH), index width (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock; one clock domain, no other clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  truth-table word offered
- in_ready  out  1  encoder can accept a word
- in_truth  in  WIDTH  bit k = F(k), where k = {x,y,z} for WIDTH=8
- in_pos  in  1  0 = list minterms (bits = 1); 1 = list maxterms (bits = 0)
- out_valid  out  1  index beat valid
- out_ready  in  1  consumer accepts beat
- out_idx  out  IDX_W  term index
- out_last  out  1  final beat of current word
- out_empty  out  1  word has no terms; beat carries no index
- out_count  out  IDX_W+1  total terms in current word, constant for all beats of the word

## Operation
- States: IDLE, EMIT (enum in package).
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready, load mask = in_pos ? ~in_truth : in_truth.
  - Load out_count = popcount(mask).
  - Go to EMIT.
- EMIT:
  - in_ready=0, out_valid=1.
  - out_idx = index of lowest set bit of mask.
  - out_last = (mask has exactly one bit set) or mask==0.
  - out_empty = (mask==0); out_idx=0 in this case.
- Handshake out_valid&&out_ready:
  - Clear the lowest set bit of mask.
  - If out_last, return to IDLE; otherwise stay in EMIT.
- Empty word (all-ones in POS, all-zeros in SOP): exactly one beat with out_empty=1, out_last=1, out_count=0.
- Full word (all terms present): WIDTH beats, indices 0..WIDTH-1, out_count=WIDTH. The extra count bit is required for this case.
- Backpressure: while out_valid && !out_ready, hold out_idx, out_last, out_empty and out_count stable.
- in_truth and in_pos are sampled only at acceptance. Later input changes do not affect the word in flight.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert handled upstream):
  - State=IDLE, mask=0.
  - out_valid=0, out_idx=0, out_last=0, out_empty=0, out_count=0, in_ready=1.
- Reset mid-word aborts the word immediately. No further beats are emitted.
- Latency: word accepted at edge N → first beat valid after edge N, i.e. visible in cycle N+1.
- Throughput: one beat per cycle while out_ready=1. A word of n terms occupies n cycles in EMIT (1 cycle if empty).
- No overlap: the next word cannot be accepted in the cycle of the last beat. in_ready rises in the cycle after the last handshake, so there is a 1-cycle bubble per word.
- Outputs are registered or derived only from registered mask and state. There is no combinational path from in_* or out_ready to out_*.

## Structure
- Package minterm_enc_pkg:
  - state enum {IDLE, EMIT}
  - localparam default WIDTH=8
  - popcount function
- Sub-module lsb_priority_enc, purely combinational:
  - Input: mask[WIDTH-1:0].
  - Outputs: idx[IDX_W-1:0], onehot[WIDTH-1:0] of the lowest set bit, any, single.
  - The top level clears the bit with mask & ~onehot.
- Top level holds the FSM, the mask register, the count register and the handshake.

## Test plan
- SOP, in_truth=8'b1110_0110, out_ready=1 → beats idx 1,2,5,6,7; out_last only on 7; out_count=5 on all beats.
- POS, same word (F=ΠM(0,3,4)) → beats 0,3,4; last on 4; out_count=3.
- POS, in_truth=8'b1101_1011 (ΠM(2,5)), with out_ready toggling 1,0,0,1 → beat 2 accepted, idx 5 held stable for 2 stalled cycles, then accepted with out_last=1.
- Edge words:
  - SOP 8'h00 → single beat, out_empty=1, out_last=1, out_count=0.
  - SOP 8'hFF → 8 beats 0..7, out_count=8.
  - in_ready=0 throughout, and in_valid held high accepts the next word exactly 1 cycle after the last beat.
- rst_n pulsed low asynchronously during the 2nd beat of SOP 8'hF0 → out_valid drops in the same cycle. After release in_ready=1 and no stale beats appear. A new word 8'h01 yields the single beat idx 0.
- Random truth words and modes, back-to-back, random out_ready → a scoreboard check that beat indices equal the set bits of the mode-adjusted mask in ascending order, and that count and last are consistent.

Source files
------------

// File: rtl/minterm_enc_pkg.sv
// Shared types and helpers for the minterm/maxterm list encoder.
package minterm_enc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH = 8;
  // Widest truth table the popcount helper can count.
  localparam int MAX_W = 64;

  function automatic int unsigned popcount(input logic [MAX_W-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < MAX_W; i++) begin
      cnt = cnt + 32'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/lsb_priority_enc.sv
// Combinational lowest-set-bit encoder: index, one-hot of that bit, any/single flags.
module lsb_priority_enc #(
  parameter  int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] mask,
  output logic [IDX_W-1:0] idx,
  output logic [WIDTH-1:0] onehot,
  output logic             any,
  output logic             single
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (mask[i]) idx = IDX_W'(i);
    end
  end

  assign onehot = mask & (~mask + WIDTH'(1));
  assign any    = |mask;
  assign single = any && ((mask & ~onehot) == '0);

endmodule

// File: rtl/minterm_list_encoder.sv
// Serialises a truth-table word into its ascending minterm (SOP) or maxterm (POS) index list.
module minterm_list_encoder
  import minterm_enc_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_truth,
  input  logic             in_pos,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_empty,
  output logic [IDX_W:0]   out_count
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mask_q, mask_d;
  logic [IDX_W:0]     count_q, count_d;

  logic [IDX_W-1:0]   pe_idx;
  logic [WIDTH-1:0]   pe_onehot;
  logic               pe_any;
  logic               pe_single;
  logic [WIDTH-1:0]   load_mask;
  logic               emit;

  lsb_priority_enc #(.WIDTH(WIDTH)) u_pe (
    .mask   (mask_q),
    .idx    (pe_idx),
    .onehot (pe_onehot),
    .any    (pe_any),
    .single (pe_single)
  );

  assign emit      = (state_q == EMIT);
  assign load_mask = in_pos ? ~in_truth : in_truth;

  // Every output comes from registered state/mask/count only.
  assign in_ready  = !emit;
  assign out_valid = emit;
  assign out_idx   = pe_idx;
  assign out_last  = emit && (pe_single || !pe_any);
  assign out_empty = emit && !pe_any;
  assign out_count = count_q;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mask_d  = load_mask;
          count_d = (IDX_W + 1)'(popcount(MAX_W'(load_mask)));
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          mask_d = mask_q & ~pe_onehot;
          if (out_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_minterm_list_encoder.sv
// Directed and randomised bench for minterm_list_encoder (WIDTH=8).
module tb_minterm_list_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_truth;
  logic       in_pos;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic       out_last;
  logic       out_empty;
  logic [3:0] out_count;

  int checks = 0;
  int errors = 0;

  int b_idx[$];
  int b_last[$];
  int b_empty[$];
  int b_count[$];
  int b_rdy[$];

  minterm_list_encoder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_truth  (in_truth),
    .in_pos    (in_pos),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_empty (out_empty),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  // Called at a negedge while idle; returns at the negedge where the first beat is visible.
  task automatic send_word(input logic [7:0] t, input logic p);
    in_valid = 1'b1;
    in_truth = t;
    in_pos   = p;
    @(negedge clk);
    in_valid = 1'b0;
    in_truth = ~t;
    in_pos   = ~p;
  endtask

  // Records every accepted beat; returns at the negedge after the last handshake.
  task automatic collect(input bit rand_ready, output bit timeout);
    bit r;
    b_idx.delete(); b_last.delete(); b_empty.delete(); b_count.delete(); b_rdy.delete();
    timeout = 1'b1;
    for (int c = 0; c < 200; c++) begin
      r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = r;
      if (out_valid && r) begin
        b_idx.push_back(int'(out_idx));
        b_last.push_back(int'(out_last));
        b_empty.push_back(int'(out_empty));
        b_count.push_back(int'(out_count));
        b_rdy.push_back(int'(in_ready));
        if (out_last) begin
          @(negedge clk);
          out_ready = 1'b0;
          timeout = 1'b0;
          return;
        end
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_idx !== 3'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", out_idx); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b exp 0", out_last); end
    checks++; if (out_empty !== 1'b0) begin errors++; $display("FAIL reset_empty got %b exp 0", out_empty); end
    checks++; if (out_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", out_count); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_idle got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_sop_basic();
    int exp_idx[5] = '{1, 2, 5, 6, 7};
    bit to;
    send_word(8'b1110_0110, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sop_latency got valid=%b exp 1", out_valid); end
    collect(1'b0, to);
    checks++; if (to || b_idx.size() != 5) begin errors++; $display("FAIL sop_beats got %0d timeout=%0d exp 5", b_idx.size(), to); end
    for (int k = 0; k < b_idx.size() && k < 5; k++) begin
      checks++; if (b_idx[k] != exp_idx[k]) begin errors++; $display("FAIL sop_idx[%0d] got %0d exp %0d", k, b_idx[k], exp_idx[k]); end
      checks++; if (b_last[k] != (k == 4 ? 1 : 0)) begin errors++; $display("FAIL sop_last[%0d] got %0d exp %0d", k, b_last[k], k == 4); end
      checks++; if (b_count[k] != 5) begin errors++; $display("FAIL sop_count[%0d] got %0d exp 5", k, b_count[k]); end
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sop_ready_after got %b exp 1", in_ready); end
  endtask

  task automatic test_pos_basic();
    int exp_idx[3] = '{0, 3, 4};
    bit to;
    send_word(8'b1110_0110, 1'b1);
    collect(1'b0, to);
    checks++; if (to || b_idx.size() != 3) begin errors++; $display("FAIL pos_beats got %0d timeout=%0d exp 3", b_idx.size(), to); end
    for (int k = 0; k < b_idx.size() && k < 3; k++) begin
      checks++; if (b_idx[k] != exp_idx[k]) begin errors++; $display("FAIL pos_idx[%0d] got %0d exp %0d", k, b_idx[k], exp_idx[k]); end
      checks++; if (b_last[k] != (k == 2 ? 1 : 0)) begin errors++; $display("FAIL pos_last[%0d] got %0d exp %0d", k, b_last[k], k == 2); end
      checks++; if (b_count[k] != 3) begin errors++; $display("FAIL pos_count[%0d] got %0d exp 3", k, b_count[k]); end
    end
  endtask

  task automatic test_backpressure();
    send_word(8'b1101_1011, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_idx !== 3'd2 || out_last !== 1'b0 || out_count !== 4'd2) begin
      errors++; $display("FAIL bp_first got v=%b idx=%0d last=%b cnt=%0d exp v=1 idx=2 last=0 cnt=2", out_valid, out_idx, out_last, out_count);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      checks++; if (out_valid !== 1'b1 || out_idx !== 3'd5 || out_last !== 1'b1 || out_empty !== 1'b0 || out_count !== 4'd2) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b idx=%0d last=%b empty=%b cnt=%0d exp v=1 idx=5 last=1 empty=0 cnt=2",
                           s, out_valid, out_idx, out_last, out_empty, out_count);
      end
      if (s == 2) out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_done got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_empty_word();
    bit to;
    send_word(8'h00, 1'b0);
    collect(1'b0, to);
    checks++; if (to || b_idx.size() != 1) begin errors++; $display("FAIL empty_beats got %0d timeout=%0d exp 1", b_idx.size(), to); end
    if (b_idx.size() >= 1) begin
      checks++; if (b_empty[0] != 1 || b_last[0] != 1) begin errors++; $display("FAIL empty_flags got empty=%0d last=%0d exp 1 1", b_empty[0], b_last[0]); end
      checks++; if (b_count[0] != 0 || b_idx[0] != 0) begin errors++; $display("FAIL empty_cnt_idx got cnt=%0d idx=%0d exp 0 0", b_count[0], b_idx[0]); end
    end
  endtask

  task automatic test_full_word();
    bit to;
    send_word(8'hFF, 1'b0);
    collect(1'b0, to);
    checks++; if (to || b_idx.size() != 8) begin errors++; $display("FAIL full_beats got %0d timeout=%0d exp 8", b_idx.size(), to); end
    for (int k = 0; k < b_idx.size() && k < 8; k++) begin
      checks++; if (b_idx[k] != k || b_count[k] != 8 || b_rdy[k] != 0 || b_empty[k] != 0) begin
        errors++; $display("FAIL full_beat[%0d] got idx=%0d cnt=%0d rdy=%0d empty=%0d exp idx=%0d cnt=8 rdy=0 empty=0",
                           k, b_idx[k], b_count[k], b_rdy[k], b_empty[k], k);
      end
      checks++; if (b_last[k] != (k == 7 ? 1 : 0)) begin errors++; $display("FAIL full_last[%0d] got %0d exp %0d", k, b_last[k], k == 7); end
    end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_truth = 8'h81; in_pos = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    in_truth = 8'h02;
    checks++; if (out_valid !== 1'b1 || out_idx !== 3'd0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_beat0 got v=%b idx=%0d rdy=%b exp v=1 idx=0 rdy=0", out_valid, out_idx, in_ready);
    end
    @(negedge clk);
    checks++; if (out_idx !== 3'd7 || out_last !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_beat1 got idx=%0d last=%b rdy=%b exp idx=7 last=1 rdy=0", out_idx, out_last, in_ready);
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_bubble got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_idx !== 3'd1 || out_last !== 1'b1 || out_count !== 4'd1) begin
      errors++; $display("FAIL b2b_second got v=%b idx=%0d last=%b cnt=%0d exp v=1 idx=1 last=1 cnt=1", out_valid, out_idx, out_last, out_count);
    end
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got v=%b exp 0", out_valid); end
  endtask

  task automatic test_reset_mid_word();
    bit to;
    send_word(8'hF0, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_idx !== 3'd5) begin errors++; $display("FAIL rst_mid_second got idx=%0d exp 5", out_idx); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_abort got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL rst_mid_stale[%0d] got v=%b rdy=%b exp v=0 rdy=1", c, out_valid, in_ready);
      end
    end
    out_ready = 1'b0;
    send_word(8'h01, 1'b0);
    collect(1'b0, to);
    checks++; if (to || b_idx.size() != 1) begin errors++; $display("FAIL rst_mid_new_beats got %0d timeout=%0d exp 1", b_idx.size(), to); end
    if (b_idx.size() >= 1) begin
      checks++; if (b_idx[0] != 0 || b_last[0] != 1 || b_count[0] != 1) begin
        errors++; $display("FAIL rst_mid_new got idx=%0d last=%0d cnt=%0d exp 0 1 1", b_idx[0], b_last[0], b_count[0]);
      end
    end
  endtask

  task automatic test_random();
    bit to;
    logic [7:0] t, m;
    logic p;
    int exp_q[$];
    int n;
    for (int w = 0; w < 30; w++) begin
      t = 8'($urandom);
      if (w == 3) t = 8'hFF;
      if (w == 4) t = 8'h00;
      p = 1'($urandom_range(0, 1));
      m = p ? ~t : t;
      exp_q.delete();
      for (int b = 0; b < 8; b++) if (m[b]) exp_q.push_back(b);
      n = exp_q.size();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rnd_ready[%0d] got %b exp 1", w, in_ready); end
      send_word(t, p);
      collect(1'b1, to);
      checks++; if (to || b_idx.size() != (n == 0 ? 1 : n)) begin
        errors++; $display("FAIL rnd_beats[%0d] t=%h p=%0d got %0d timeout=%0d exp %0d", w, t, p, b_idx.size(), to, (n == 0 ? 1 : n));
      end
      for (int k = 0; k < b_idx.size(); k++) begin
        checks++;
        if (b_count[k] != n || b_empty[k] != (n == 0 ? 1 : 0) || b_last[k] != (k == b_idx.size() - 1 ? 1 : 0) ||
            b_idx[k] != (n == 0 ? 0 : (k < n ? exp_q[k] : -1))) begin
          errors++; $display("FAIL rnd_beat[%0d][%0d] t=%h p=%0d got idx=%0d cnt=%0d last=%0d empty=%0d exp idx=%0d cnt=%0d",
                             w, k, t, p, b_idx[k], b_count[k], b_last[k], b_empty[k], (n == 0 || k >= n) ? 0 : exp_q[k], n);
        end
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_truth  = 8'h00;
    in_pos    = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_sop_basic();
    test_pos_basic();
    test_backpressure();
    test_empty_word();
    test_full_word();
    test_back_to_back();
    test_reset_mid_word();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
